spi_readout_shifter: RTL and testbench
======================================

Name: spi_readout_shifter

Overview:
Transmit side of the SPI peripheral. On a read request it fetches bytes from the register map through an auto-incrementing address pointer and serializes them MSB-first onto serial_out, one bit per sclk. It covers the trigger mask, instruction and mode registers at addresses 1-3 and the analog-register bytes at addresses 4-59. It runs back-to-back bytes with no bubble, and the output line idles low.

Parameters:
ADDR_W, 8, address pointer width
DATA_W, 8, bits per serialized byte
MIN_ADDR, 1, lowest readable address; the pointer wraps to this value
MAX_ADDR, 59, highest readable address

Ports:
sclk  input  1  SPI clock; all state updates on posedge
rstn  input  1  reset, asynchronous, active-low
rd_req  input  1  start pulse, sampled on posedge sclk, honoured only in IDLE
rd_start_addr  input  ADDR_W  first address, captured with rd_req
rd_len  input  8  byte count, captured with rd_req; 0 = continuous until abort
abort  input  1  synchronous stop, highest priority below rstn
rd_data  input  DATA_W  combinational register-map read data at rd_ptr
rd_ptr  output  ADDR_W  prefetch address driven to the register map
serial_out  output  1  registered serial data, MSB first
busy  output  1  high in LOAD and SHIFT
byte_done  output  1  one-cycle pulse after the last bit of each byte
done  output  1  one-cycle pulse when a finite-length read completes normally

Behaviour:
- Reset (rstn low, asynchronous):
  - state=IDLE; rd_ptr=MIN_ADDR; shift reg, bit_cnt and byte_cnt = 0.
  - serial_out, busy, byte_done and done = 0.
- States and transitions:
  - IDLE: serial_out=0. rd_req=1 and abort=0 -> rd_ptr<=rd_start_addr, latch rd_len, go to LOAD.
  - LOAD (one cycle, first byte only):
    - shreg<=sel_data, where sel_data=rd_data if MIN_ADDR<=rd_ptr<=MAX_ADDR, else 0x00.
    - serial_out<=sel_data[7]; bit_cnt<=7; rd_ptr<=next(rd_ptr); go to SHIFT.
  - SHIFT, bit_cnt>0: shreg<<=1; serial_out<=next bit; bit_cnt--.
  - SHIFT, bit_cnt==0 (current byte's bit0 on line):
    - byte_done<=1; byte_cnt++.
    - If len!=0 and byte_cnt+1==len: go to IDLE, serial_out<=0, done<=1.
    - Otherwise reload: shreg<=sel_data, serial_out<=sel_data[7], bit_cnt<=7, rd_ptr<=next(rd_ptr). This gives a seamless 8-sclk byte period.
- next(p) = MIN_ADDR if p>=MAX_ADDR, else p+1. Wrap 59 -> 1.
- Latency:
  - rd_req sampled at edge N; bit7 of the first byte is valid after edge N+1.
  - bit0 of byte k (0-based) is valid after edge N+8+8k.
- rd_ptr always holds the address of the next byte to load, not the byte on the line.
- Out-of-range start address (0 or >59): those bytes transmit 0x00. The pointer still advances; once past MAX_ADDR it wraps to MIN_ADDR.
- rd_req while busy: ignored, with no side effects.
- abort: IDLE on the next edge. serial_out=0; done and byte_done=0; rd_ptr holds its value.
- abort together with rd_req in IDLE: abort wins and the request is dropped.
- abort on the final-bit edge: abort wins; no byte_done, no done.
- byte_cnt is 8 bits. In continuous mode it wraps freely and never terminates the read.
- rstn asserted mid-byte: immediate return to reset values; the partial byte is lost.

Decomposition:
- Shared package spi_pkg holds:
  - typedef state_t {IDLE, LOAD, SHIFT}.
  - Constants MIN_ADDR=1, MAX_ADDR=59, and SPECIAL_REG_LAST=3 (shared with the write path).
  - Function addr_next().
- One natural sub-module: piso_shift8, the loadable parallel-in/serial-out register with bit counter. The FSM, pointer and counters stay in the top module.

Test Plan:
- Map addr1=0xA5, addr2=0x3C; rd_req with start=1, len=2 -> serial_out bits 10100101 00111100 on edges N+1..N+16; byte_done at N+9 and N+17; done at N+17; rd_ptr=3 at the end.
- Wrap: start=58, len=3, map 58=0x11, 59=0x22, 1=0x33 -> bytes 0x11,0x22,0x33 sent; rd_ptr sequence 58,59,1,2.
- Out of range: start=0, len=2, addr1=0xFF -> 0x00 then 0xFF sent; done asserted.
- Continuous: len=0, start=4, run 100 bytes -> no done pulse; byte_done every 8 edges; pointer wraps 59->1 once it passes 59.
- Abort after bit 3 of byte 0 -> next edge busy=0, serial_out=0, no byte_done, no done; a following rd_req is accepted normally.
- rd_req pulsed while busy plus async rstn mid-byte -> second request ignored; on reset all outputs 0 and rd_ptr=1 immediately, without waiting for an sclk edge.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: readout FSM states, register-map address limits
// and the auto-increment rule for the address pointer.
package spi_pkg;

  localparam int unsigned ADDR_W           = 8;
  localparam int unsigned DATA_W           = 8;
  localparam int unsigned MIN_ADDR         = 1;
  localparam int unsigned MAX_ADDR         = 59;
  localparam int unsigned SPECIAL_REG_LAST = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // Pointer auto-increment; anything at or beyond the top of the map wraps to lo.
  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] p,
                                                  input int unsigned       lo,
                                                  input int unsigned       hi);
    if (32'(p) >= hi) begin
      return lo[ADDR_W-1:0];
    end
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/spi_readout_shifter_piso_shift8.sv
// Loadable parallel-in/serial-out register with bit counter. The MSB of the
// shift register is the serial line itself, so the line is always registered.
module piso_shift8 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              sclk,
  input  logic              rstn,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              ser_o,
  output logic              last_bit_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

  always_comb begin
    // NOTE: every target gets its hold value first, so no path through the
    // block leaves it unassigned and no latch is inferred.
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (clear_i) begin
      shreg_d   = '0;
      bit_cnt_d = '0;
    end else if (load_i) begin
      shreg_d   = load_data_i;
      bit_cnt_d = CNT_W'(DATA_W - 1);
    end else if (shift_i) begin
      shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign ser_o      = shreg_q[DATA_W-1];
  assign last_bit_o = (bit_cnt_q == '0);

endmodule

// File: rtl/spi_readout_shifter.sv
// SPI transmit path: fetches register-map bytes through an auto-incrementing
// pointer and serializes them MSB-first, back-to-back, one bit per sclk.
module spi_readout_shifter #(
  parameter int unsigned ADDR_W   = spi_pkg::ADDR_W,
  parameter int unsigned DATA_W   = spi_pkg::DATA_W,
  parameter int unsigned MIN_ADDR = spi_pkg::MIN_ADDR,
  parameter int unsigned MAX_ADDR = spi_pkg::MAX_ADDR
) (
  input  logic              sclk,
  input  logic              rstn,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_start_addr,
  input  logic [7:0]        rd_len,
  input  logic              abort,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic              serial_out,
  output logic              busy,
  output logic              byte_done,
  output logic              done
);

  import spi_pkg::*;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        byte_cnt_q, byte_cnt_d;
  logic              byte_done_q, byte_done_d;
  logic              done_q, done_d;

  logic              piso_clear;
  logic              piso_load;
  logic              piso_shift;
  logic              piso_last;
  logic              ptr_in_range;
  logic [DATA_W-1:0] sel_data;

  // Addresses outside the readable window transmit zeros.
  assign ptr_in_range = (32'(rd_ptr_q) >= MIN_ADDR) && (32'(rd_ptr_q) <= MAX_ADDR);
  assign sel_data     = ptr_in_range ? rd_data : '0;

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    byte_done_d = 1'b0;
    done_d      = 1'b0;
    piso_clear  = 1'b0;
    piso_load   = 1'b0;
    piso_shift  = 1'b0;

    if (abort) begin
      state_d    = IDLE;
      piso_clear = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          piso_clear = 1'b1;
          if (rd_req) begin
            rd_ptr_d   = rd_start_addr;
            len_d      = rd_len;
            byte_cnt_d = '0;
            state_d    = LOAD;
          end
        end
        LOAD: begin
          piso_load = 1'b1;
          rd_ptr_d  = addr_next(rd_ptr_q, MIN_ADDR, MAX_ADDR);
          state_d   = SHIFT;
        end
        SHIFT: begin
          if (!piso_last) begin
            piso_shift = 1'b1;
          end else begin
            byte_done_d = 1'b1;
            byte_cnt_d  = byte_cnt_q + 8'd1;
            // A zero length means stream until aborted; the counter just wraps.
            if ((len_q != 8'd0) && (byte_cnt_q + 8'd1 == len_q)) begin
              state_d    = IDLE;
              piso_clear = 1'b1;
              done_d     = 1'b1;
            end else begin
              piso_load = 1'b1;
              rd_ptr_d  = addr_next(rd_ptr_q, MIN_ADDR, MAX_ADDR);
            end
          end
        end
        default: begin
          state_d    = IDLE;
          piso_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rd_ptr_q    <= ADDR_W'(MIN_ADDR);
      len_q       <= '0;
      byte_cnt_q  <= '0;
      byte_done_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      byte_done_q <= byte_done_d;
      done_q      <= done_d;
    end
  end

  piso_shift8 #(
    .DATA_W (DATA_W)
  ) u_piso (
    .sclk        (sclk),
    .rstn        (rstn),
    .clear_i     (piso_clear),
    .load_i      (piso_load),
    .shift_i     (piso_shift),
    .load_data_i (sel_data),
    .ser_o       (serial_out),
    .last_bit_o  (piso_last)
  );

  assign rd_ptr    = rd_ptr_q;
  assign busy      = (state_q != IDLE);
  assign byte_done = byte_done_q;
  assign done      = done_q;

endmodule

// File: tb/tb_spi_readout_shifter.sv
// Bench for spi_readout_shifter: a transaction-level model predicts every
// output from the request time, plus directed scenarios with literal values.
module tb_spi_readout_shifter;

  localparam int MINA = 1;
  localparam int MAXA = 59;
  localparam int SPAN = MAXA - MINA + 1;

  logic       sclk = 1'b0;
  logic       rstn = 1'b1;
  logic       rd_req = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] rd_start_addr = 8'd0;
  logic [7:0] rd_len = 8'd0;
  logic [7:0] rd_data;
  logic [7:0] rd_ptr;
  logic       serial_out, busy, byte_done, done;

  logic [7:0] mem [0:255];
  assign rd_data = mem[rd_ptr];

  always #5 sclk = ~sclk;

  spi_readout_shifter dut (
    .sclk          (sclk),
    .rstn          (rstn),
    .rd_req        (rd_req),
    .rd_start_addr (rd_start_addr),
    .rd_len        (rd_len),
    .abort         (abort),
    .rd_data       (rd_data),
    .rd_ptr        (rd_ptr),
    .serial_out    (serial_out),
    .busy          (busy),
    .byte_done     (byte_done),
    .done          (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_active = 1'b0;
  int         cyc = 0;
  int         m_n = 0;
  logic [7:0] m_start = 8'd0;
  logic [7:0] m_len = 8'd0;
  logic [7:0] m_idle_ptr = 8'd1;
  logic       e_ser = 1'b0, e_busy = 1'b0, e_bd = 1'b0, e_done = 1'b0;
  logic [7:0] e_ptr = 8'd1;

  // Address reached after k pointer steps from a (closed form over the 1..59 ring).
  function automatic logic [7:0] adv(input logic [7:0] a, input int k);
    int ai;
    ai = int'(a);
    if (k == 0) return a;
    if (ai >= MINA && ai <= MAXA) return 8'((ai - MINA + k) % SPAN + MINA);
    return 8'((k - 1) % SPAN + MINA);
  endfunction

  function automatic logic [7:0] byte_at(input int k);
    logic [7:0] a;
    int ai;
    a  = adv(m_start, k);
    ai = int'(a);
    return (ai >= MINA && ai <= MAXA) ? mem[a] : 8'h00;
  endfunction

  // Pointer value after edge N+t: one step per byte fetched so far.
  function automatic logic [7:0] ptr_at(input int t);
    int loads;
    if (t == 0) return m_start;
    loads = (t - 1) / 8 + 1;
    if (m_len != 8'd0 && loads > int'(m_len)) loads = int'(m_len);
    return adv(m_start, loads);
  endfunction

  task automatic model_idle();
    e_ser = 1'b0; e_busy = 1'b0; e_bd = 1'b0; e_done = 1'b0; e_ptr = m_idle_ptr;
  endtask

  always @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      m_active   = 1'b0;
      m_idle_ptr = 8'd1;
      model_idle();
    end else begin
      cyc++;
      if (m_active && abort) begin
        m_active   = 1'b0;
        m_idle_ptr = ptr_at(cyc - m_n - 1);
        model_idle();
      end else if (m_active) begin
        int t, len, k, b;
        logic [7:0] bv;
        t      = cyc - m_n;
        len    = int'(m_len);
        e_busy = (len == 0) || (t <= 8 * len);
        if (e_busy && t >= 1) begin
          k     = (t - 1) / 8;
          b     = 7 - ((t - 1) % 8);
          bv    = byte_at(k);
          e_ser = bv[b];
        end else begin
          e_ser = 1'b0;
        end
        e_bd   = (t >= 9) && ((t - 1) % 8 == 0);
        e_done = (len != 0) && (t == 8 * len + 1);
        e_ptr  = ptr_at(t);
        if (e_done) begin
          m_active   = 1'b0;
          m_idle_ptr = e_ptr;
        end
      end else if (rd_req && !abort) begin
        m_active = 1'b1;
        m_n      = cyc;
        m_start  = rd_start_addr;
        m_len    = rd_len;
        e_ser = 1'b0; e_busy = 1'b1; e_bd = 1'b0; e_done = 1'b0; e_ptr = rd_start_addr;
      end else begin
        model_idle();
      end
    end
  end

  always @(negedge sclk) begin
    if (rstn) begin
      check("serial_out", 32'(serial_out), 32'(e_ser));
      check("busy",       32'(busy),       32'(e_busy));
      check("byte_done",  32'(byte_done),  32'(e_bd));
      check("done",       32'(done),       32'(e_done));
      check("rd_ptr",     32'(rd_ptr),     32'(e_ptr));
    end
  end

  int bd_cnt = 0;
  int done_cnt = 0;
  always @(negedge sclk) begin
    if (rstn) begin
      if (byte_done === 1'b1) bd_cnt++;
      if (done === 1'b1) done_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cyc();
    @(negedge sclk);
    #1;
  endtask

  task automatic start_read(input logic [7:0] a, input logic [7:0] l);
    rd_start_addr = a;
    rd_len        = l;
    rd_req        = 1'b1;
    next_cyc();
    rd_req = 1'b0;
  endtask

  task automatic capture(input int nbits, output logic [31:0] v);
    v = '0;
    repeat (nbits) begin
      next_cyc();
      v = {v[30:0], serial_out};
    end
  endtask

  task automatic clr_cnt();
    bd_cnt   = 0;
    done_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset values
    #2 rstn = 1'b0;
    #1;
    check("reset_serial_out", 32'(serial_out), 0);
    check("reset_busy",       32'(busy),       0);
    check("reset_byte_done",  32'(byte_done),  0);
    check("reset_done",       32'(done),       0);
    check("reset_rd_ptr",     32'(rd_ptr),     1);
    next_cyc();
    next_cyc();
    rstn = 1'b1;
    next_cyc();

    // Basic two-byte read
    mem[1] = 8'hA5; mem[2] = 8'h3C;
    clr_cnt();
    start_read(8'd1, 8'd2);
    capture(16, v);
    check("t1_stream", v, 32'h0000_A53C);
    next_cyc();
    check("t1_byte_done_count", bd_cnt, 2);
    check("t1_done_count", done_cnt, 1);
    check("t1_rd_ptr", 32'(rd_ptr), 3);
    check("t1_busy", 32'(busy), 0);
    next_cyc();

    // Pointer wrap 58,59,1,2
    mem[58] = 8'h11; mem[59] = 8'h22; mem[1] = 8'h33;
    clr_cnt();
    start_read(8'd58, 8'd3);
    check("t2_ptr0", 32'(rd_ptr), 58);
    capture(8, v);
    check("t2_byte0", v, 32'h11);
    check("t2_ptr1", 32'(rd_ptr), 59);
    capture(8, v);
    check("t2_byte1", v, 32'h22);
    check("t2_ptr2", 32'(rd_ptr), 1);
    capture(8, v);
    check("t2_byte2", v, 32'h33);
    check("t2_ptr3", 32'(rd_ptr), 2);
    next_cyc();
    check("t2_done_count", done_cnt, 1);
    next_cyc();

    // Out-of-range start address transmits zero
    mem[0] = 8'h77; mem[1] = 8'hFF;
    clr_cnt();
    start_read(8'd0, 8'd2);
    capture(16, v);
    check("t3_stream", v, 32'h0000_00FF);
    next_cyc();
    check("t3_done_count", done_cnt, 1);
    check("t3_rd_ptr", 32'(rd_ptr), 2);
    next_cyc();

    // Continuous mode, 100 bytes, then abort
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    clr_cnt();
    start_read(8'd4, 8'd0);
    repeat (801) next_cyc();
    check("t4_byte_done_count", bd_cnt, 100);
    check("t4_done_count", done_cnt, 0);
    check("t4_busy", 32'(busy), 1);
    abort = 1'b1;
    next_cyc();
    abort = 1'b0;
    check("t4_abort_busy", 32'(busy), 0);
    check("t4_abort_serial", 32'(serial_out), 0);
    next_cyc();

    // Abort mid-byte, then a normal read
    mem[5] = 8'hC3; mem[10] = 8'h5A;
    clr_cnt();
    start_read(8'd5, 8'd4);
    capture(4, v);
    check("t5_partial", v, 32'hC);
    abort = 1'b1;
    next_cyc();
    abort = 1'b0;
    check("t5_busy", 32'(busy), 0);
    check("t5_serial", 32'(serial_out), 0);
    check("t5_byte_done_count", bd_cnt, 0);
    check("t5_done_count", done_cnt, 0);
    check("t5_rd_ptr", 32'(rd_ptr), 6);
    next_cyc();
    start_read(8'd10, 8'd1);
    capture(8, v);
    check("t5_next_read", v, 32'h5A);
    next_cyc();
    check("t5_next_done", done_cnt, 1);

    // Abort together with rd_req in IDLE
    rd_start_addr = 8'd30; rd_len = 8'd2; rd_req = 1'b1; abort = 1'b1;
    next_cyc();
    rd_req = 1'b0; abort = 1'b0;
    check("t6_busy", 32'(busy), 0);
    check("t6_rd_ptr", 32'(rd_ptr), 11);
    next_cyc();

    // Abort on the final-bit edge
    clr_cnt();
    start_read(8'd12, 8'd1);
    capture(8, v);
    abort = 1'b1;
    next_cyc();
    abort = 1'b0;
    check("t7_byte_done_count", bd_cnt, 0);
    check("t7_done_count", done_cnt, 0);
    check("t7_busy", 32'(busy), 0);
    check("t7_rd_ptr", 32'(rd_ptr), 13);
    next_cyc();

    // rd_req while busy, then asynchronous reset mid-byte
    start_read(8'd20, 8'd3);
    repeat (3) next_cyc();
    rd_start_addr = 8'd40; rd_len = 8'd1; rd_req = 1'b1;
    next_cyc();
    rd_req = 1'b0;
    repeat (2) next_cyc();
    check("t8_rd_ptr_busy", 32'(rd_ptr), 21);
    #2 rstn = 1'b0;
    #1;
    check("t8_rst_serial", 32'(serial_out), 0);
    check("t8_rst_busy", 32'(busy), 0);
    check("t8_rst_byte_done", 32'(byte_done), 0);
    check("t8_rst_done", 32'(done), 0);
    check("t8_rst_rd_ptr", 32'(rd_ptr), 1);
    next_cyc();
    next_cyc();
    rstn = 1'b1;
    next_cyc();
    check("t8_post_busy", 32'(busy), 0);

    // Randomized reads against the model
    for (int s = 0; s < 30; s++) begin
      logic [7:0] a, l;
      int stop_at, c;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      l       = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 5));
      a       = 8'($urandom_range(0, 63));
      stop_at = $urandom_range(10, 300);
      start_read(a, l);
      c = 0;
      while (m_active && c < 1000) begin
        if (l == 8'd0 && c == stop_at) abort = 1'b1;
        else if ($urandom_range(0, 59) == 0) abort = 1'b1;
        if ($urandom_range(0, 9) == 0) begin
          rd_start_addr = 8'($urandom);
          rd_len        = 8'($urandom_range(1, 4));
          rd_req        = 1'b1;
        end
        next_cyc();
        abort  = 1'b0;
        rd_req = 1'b0;
        c++;
      end
      check("rand_terminated", 32'(m_active), 0);
      repeat (2) next_cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
